// File: rtl/vga_timing_gen.sv
// 640x480@60 raster timing: registered pixel counters plus blank/sync/frame strobes,
// each decoded from the next counter state so it lines up with the DrawX/DrawY it accompanies.
module vga_timing_gen #(
  parameter int unsigned H_VISIBLE  = 640,
  parameter int unsigned H_FP       = 16,
  parameter int unsigned H_SYNC     = 96,
  parameter int unsigned H_BP       = 48,
  parameter int unsigned V_VISIBLE  = 480,
  parameter int unsigned V_FP       = 10,
  parameter int unsigned V_SYNC     = 2,
  parameter int unsigned V_BP       = 33,
  parameter int unsigned SYNC_DELAY = 2
) (
  input  logic        vga_clk,
  input  logic        reset,
  output logic [9:0]  DrawX,
  output logic [9:0]  DrawY,
  output logic        blank,
  output logic        hs,
  output logic        vs,
  output logic        hs_d,
  output logic        vs_d,
  output logic        line_start,
  output logic        frame_start,
  output logic [15:0] frame_count
);

  localparam int unsigned H_TOTAL = H_VISIBLE + H_FP + H_SYNC + H_BP;
  localparam int unsigned V_TOTAL = V_VISIBLE + V_FP + V_SYNC + V_BP;

  localparam logic [9:0] L_H_LAST = 10'(H_TOTAL - 1);
  localparam logic [9:0] L_H_VIS  = 10'(H_VISIBLE);
  localparam logic [9:0] L_HS_BEG = 10'(H_VISIBLE + H_FP);
  localparam logic [9:0] L_HS_END = 10'(H_VISIBLE + H_FP + H_SYNC - 1);
  localparam logic [9:0] L_V_LAST = 10'(V_TOTAL - 1);
  localparam logic [9:0] L_V_VIS  = 10'(V_VISIBLE);
  localparam logic [9:0] L_VS_BEG = 10'(V_VISIBLE + V_FP);
  localparam logic [9:0] L_VS_END = 10'(V_VISIBLE + V_FP + V_SYNC - 1);

  logic [9:0]  r_hc;
  logic [9:0]  r_vc;
  logic        r_blank;
  logic        r_hs;
  logic        r_vs;
  logic        r_line_start;
  logic        r_frame_start;
  logic        r_started;
  logic [15:0] r_frame_count;

  logic [9:0]  w_hc_nxt;
  logic [9:0]  w_vc_nxt;
  logic        w_frame_wrap;

  always_comb begin
    w_hc_nxt     = r_hc + 10'd1;
    w_vc_nxt     = r_vc;
    w_frame_wrap = (r_hc == L_H_LAST) && (r_vc == L_V_LAST);
    if (r_hc == L_H_LAST) begin
      w_hc_nxt = '0;
      w_vc_nxt = (r_vc == L_V_LAST) ? '0 : r_vc + 10'd1;
    end
  end

  // The reset pre-roll parks the counters on the last pixel so the first free-running
  // edge lands on (0,0); r_started keeps that first wrap from counting as a frame.
  always_ff @(posedge vga_clk) begin
    if (reset) begin
      r_hc          <= L_H_LAST;
      r_vc          <= L_V_LAST;
      r_blank       <= 1'b0;
      r_hs          <= 1'b1;
      r_vs          <= 1'b1;
      r_line_start  <= 1'b0;
      r_frame_start <= 1'b0;
      r_started     <= 1'b0;
      r_frame_count <= '0;
    end else begin
      r_hc          <= w_hc_nxt;
      r_vc          <= w_vc_nxt;
      r_blank       <= (w_hc_nxt < L_H_VIS) && (w_vc_nxt < L_V_VIS);
      r_hs          <= !((w_hc_nxt >= L_HS_BEG) && (w_hc_nxt <= L_HS_END));
      r_vs          <= !((w_vc_nxt >= L_VS_BEG) && (w_vc_nxt <= L_VS_END));
      r_line_start  <= (w_hc_nxt == '0);
      r_frame_start <= (w_hc_nxt == '0) && (w_vc_nxt == '0);
      r_started     <= 1'b1;
      if (w_frame_wrap && r_started) begin
        r_frame_count <= r_frame_count + 16'd1;
      end
    end
  end

  generate
    if (SYNC_DELAY == 0) begin : g_no_delay
      assign hs_d = r_hs;
      assign vs_d = r_vs;
    end else begin : g_delay
      logic [SYNC_DELAY-1:0] r_hs_pipe;
      logic [SYNC_DELAY-1:0] r_vs_pipe;

      always_ff @(posedge vga_clk) begin
        if (reset) begin
          r_hs_pipe <= '1;
          r_vs_pipe <= '1;
        end else begin
          r_hs_pipe[0] <= r_hs;
          r_vs_pipe[0] <= r_vs;
          for (int i = 1; i < SYNC_DELAY; i++) begin
            r_hs_pipe[i] <= r_hs_pipe[i-1];
            r_vs_pipe[i] <= r_vs_pipe[i-1];
          end
        end
      end

      assign hs_d = r_hs_pipe[SYNC_DELAY-1];
      assign vs_d = r_vs_pipe[SYNC_DELAY-1];
    end
  endgenerate

  assign DrawX       = r_hc;
  assign DrawY       = r_vc;
  assign blank       = r_blank;
  assign hs          = r_hs;
  assign vs          = r_vs;
  assign line_start  = r_line_start;
  assign frame_start = r_frame_start;
  assign frame_count = r_frame_count;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen: a full-size instance plus two reduced-raster instances (delayed and
// pass-through sync) so whole frames fit in a short run; expectations come from cycle-index arithmetic.
module tb_vga_timing_gen;

  localparam int W  = 43;
  localparam int ND = 3;

  // Geometry per instance: 0 = 640x480 default, 1 = tiny raster SYNC_DELAY=2, 2 = tiny raster SYNC_DELAY=0
  localparam int G_HV  [ND] = '{640, 8, 8};
  localparam int G_HFP [ND] = '{16,  2, 2};
  localparam int G_HSY [ND] = '{96,  3, 3};
  localparam int G_HBP [ND] = '{48,  3, 3};
  localparam int G_VV  [ND] = '{480, 6, 6};
  localparam int G_VFP [ND] = '{10,  2, 2};
  localparam int G_VSY [ND] = '{2,   2, 2};
  localparam int G_VBP [ND] = '{33,  2, 2};
  localparam int G_SD  [ND] = '{2,   2, 0};

  logic        vga_clk = 1'b0;
  logic        reset   = 1'b1;
  logic [9:0]  dx  [ND];
  logic [9:0]  dy  [ND];
  logic        bl  [ND];
  logic        hs  [ND];
  logic        vs  [ND];
  logic        hsd [ND];
  logic        vsd [ND];
  logic        ls  [ND];
  logic        fs  [ND];
  logic [15:0] fc  [ND];

  logic [W-1:0] exp_q[$];
  int           n_vec = 0;
  int           n_err = 0;
  string        tag [ND] = '{"full", "tiny_sd2", "tiny_sd0"};

  always #5 vga_clk = ~vga_clk;

  vga_timing_gen u_full (
    .vga_clk(vga_clk), .reset(reset), .DrawX(dx[0]), .DrawY(dy[0]), .blank(bl[0]),
    .hs(hs[0]), .vs(vs[0]), .hs_d(hsd[0]), .vs_d(vsd[0]), .line_start(ls[0]),
    .frame_start(fs[0]), .frame_count(fc[0])
  );

  vga_timing_gen #(
    .H_VISIBLE(8), .H_FP(2), .H_SYNC(3), .H_BP(3),
    .V_VISIBLE(6), .V_FP(2), .V_SYNC(2), .V_BP(2), .SYNC_DELAY(2)
  ) u_tiny_sd2 (
    .vga_clk(vga_clk), .reset(reset), .DrawX(dx[1]), .DrawY(dy[1]), .blank(bl[1]),
    .hs(hs[1]), .vs(vs[1]), .hs_d(hsd[1]), .vs_d(vsd[1]), .line_start(ls[1]),
    .frame_start(fs[1]), .frame_count(fc[1])
  );

  vga_timing_gen #(
    .H_VISIBLE(8), .H_FP(2), .H_SYNC(3), .H_BP(3),
    .V_VISIBLE(6), .V_FP(2), .V_SYNC(2), .V_BP(2), .SYNC_DELAY(0)
  ) u_tiny_sd0 (
    .vga_clk(vga_clk), .reset(reset), .DrawX(dx[2]), .DrawY(dy[2]), .blank(bl[2]),
    .hs(hs[2]), .vs(vs[2]), .hs_d(hsd[2]), .vs_d(vsd[2]), .line_start(ls[2]),
    .frame_start(fs[2]), .frame_count(fc[2])
  );

  function automatic int h_total(int g);
    return G_HV[g] + G_HFP[g] + G_HSY[g] + G_HBP[g];
  endfunction

  function automatic int v_total(int g);
    return G_VV[g] + G_VFP[g] + G_VSY[g] + G_VBP[g];
  endfunction

  // n = cycles since reset release (0 = first free-running edge); negative = reset or earlier.
  function automatic logic h_sync_at(int g, int n);
    int x;
    if (n < 0) return 1'b1;
    x = n % h_total(g);
    return !((x >= G_HV[g] + G_HFP[g]) && (x < G_HV[g] + G_HFP[g] + G_HSY[g]));
  endfunction

  function automatic logic v_sync_at(int g, int n);
    int y;
    if (n < 0) return 1'b1;
    y = (n / h_total(g)) % v_total(g);
    return !((y >= G_VV[g] + G_VFP[g]) && (y < G_VV[g] + G_VFP[g] + G_VSY[g]));
  endfunction

  function automatic logic [W-1:0] model(int g, int n);
    int   ht, vt, x, y, f;
    logic blank_e, ls_e, fs_e;
    ht = h_total(g);
    vt = v_total(g);
    if (n < 0) return {10'(ht - 1), 10'(vt - 1), 1'b0, 4'b1111, 2'b00, 16'd0};
    x       = n % ht;
    y       = (n / ht) % vt;
    f       = n / (ht * vt);
    blank_e = (x < G_HV[g]) && (y < G_VV[g]);
    ls_e    = (x == 0);
    fs_e    = (x == 0) && (y == 0);
    return {10'(x), 10'(y), blank_e, h_sync_at(g, n), v_sync_at(g, n),
            h_sync_at(g, n - G_SD[g]), v_sync_at(g, n - G_SD[g]), ls_e, fs_e, 16'(f)};
  endfunction

  function automatic logic [W-1:0] obs_vec(int g);
    return {dx[g], dy[g], bl[g], hs[g], vs[g], hsd[g], vsd[g], ls[g], fs[g], fc[g]};
  endfunction

  // One clock: drive reset, queue what each instance must show after the edge, then check it.
  task automatic step(input logic rst_val, input int n_next);
    logic [W-1:0] exp_v;
    logic [W-1:0] obs_v;
    @(negedge vga_clk);
    reset = rst_val;
    for (int g = 0; g < ND; g++) exp_q.push_back(model(g, n_next));
    @(posedge vga_clk);
    #1;
    for (int g = 0; g < ND; g++) begin
      exp_v = exp_q.pop_front();
      obs_v = obs_vec(g);
      n_vec++;
      assert (obs_v === exp_v) else begin
        n_err++;
        $error("FAIL %s n=%0d observed=%h expected=%h", tag[g], n_next, obs_v, exp_v);
      end
    end
  endtask

  initial begin
    int run_len;
    int tail_len;

    for (int i = 0; i < 5; i++) step(1'b1, -1);

    // Beyond two full lines of the 640x480 instance; many whole frames of the tiny rasters.
    run_len = $urandom_range(1700, 1760);
    for (int i = 0; i < run_len; i++) step(1'b0, i);

    // Single-cycle reset landing mid-line/mid-frame, then clean restart from (0,0).
    step(1'b1, -1);
    tail_len = $urandom_range(420, 460);
    for (int i = 0; i < tail_len; i++) step(1'b0, i);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
